// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback port arbiter between the pipeline and a multi-cycle-unit result FIFO
module wb_arbiter #(
    parameter int DEPTH   = 2,
    parameter int AGE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        SyscallW,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        StallW,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] pending_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(AGE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] age_q, age_d;
    logic          drain_sys_q, drain_sys_d;
    logic [4:0]    fifo_reg_q  [DEPTH];
    logic [4:0]    fifo_reg_d  [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];

    logic        pipe_req;
    logic        enq;
    logic        deq;
    logic        we_c;
    logic        stall_c;
    logic [4:0]  head_reg;
    logic [31:0] head_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign pipe_req  = RegWriteW && (WriteRegW != 5'd0);
    assign mdu_ready = (count_q < CW'(DEPTH));
    assign enq       = mdu_valid && mdu_ready;
    assign head_reg  = fifo_reg_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // Reset gates the write port and stall without waiting for a clock edge.
    assign rf_we  = rst_n && we_c;
    assign StallW = rst_n && stall_c;

    always_comb begin
        deq     = 1'b0;
        we_c    = 1'b0;
        stall_c = 1'b0;
        rf_wa   = WriteRegW;
        rf_wd   = ResultW;
        case (state_q)
            S_IDLE: begin
                we_c = pipe_req;
            end
            S_PEND: begin
                if (pipe_req) begin
                    we_c = 1'b1;
                end else begin
                    deq   = (count_q != '0);
                    we_c  = deq && (head_reg != 5'd0);
                    rf_wa = head_reg;
                    rf_wd = head_data;
                end
            end
            S_DRAIN: begin
                stall_c = 1'b1;
                deq     = (count_q != '0);
                we_c    = deq && (head_reg != 5'd0);
                rf_wa   = head_reg;
                rf_wd   = head_data;
            end
            default: begin
                we_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        fifo_reg_d  = fifo_reg_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (enq) begin
            fifo_reg_d[wr_ptr_q]  = mdu_reg;
            fifo_data_d[wr_ptr_q] = mdu_data;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    // Age measures how long the current head has been passed over by the pipeline.
    always_comb begin
        age_d = age_q;
        if (deq || (count_q == '0)) begin
            age_d = '0;
        end else if ((state_q == S_PEND) && (age_q != AW'(AGE_MAX))) begin
            age_d = age_q + AW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_sys_d = drain_sys_q;
        case (state_q)
            S_IDLE: begin
                if (enq) begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (count_d == '0) begin
                    state_d = S_IDLE;
                end else if (SyscallW) begin
                    state_d     = S_DRAIN;
                    drain_sys_d = 1'b1;
                end else if (age_d == AW'(AGE_MAX)) begin
                    state_d     = S_DRAIN;
                    drain_sys_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (count_d == '0) begin
                    state_d     = S_IDLE;
                    drain_sys_d = 1'b0;
                end else if (!drain_sys_q) begin
                    state_d = S_PEND;
                end
            end
            default: begin
                state_d     = S_IDLE;
                drain_sys_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        int off;
        pending_mask = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off = (j + DEPTH - int'(rd_ptr_q)) % DEPTH;
            if (off < int'(count_q)) begin
                pending_mask[fifo_reg_q[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            age_q       <= '0;
            drain_sys_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            age_q       <= age_d;
            drain_sys_q <= drain_sys_d;
            fifo_reg_q  <= fifo_reg_d;
            fifo_data_q <= fifo_data_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

    localparam int DEPTH   = 2;
    localparam int AGE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  WriteRegW = '0;
    logic [31:0] ResultW = '0;
    logic        SyscallW = 1'b0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_reg = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        StallW;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pending_mask;

    wb_arbiter #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW), .SyscallW(SyscallW),
        .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .StallW(StallW), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic        ready;
        logic [31:0] mask;
    } exp_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    exp_t sb[$];
    ent_t mq[$];
    int   m_age = 0;
    int   m_drain = 0;  // 0 none, 1 one forced write, 2 empty the queue
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            chk("StallW", {31'd0, StallW}, {31'd0, e.stall});
            chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, e.ready});
            chk("pending_mask", pending_mask, e.mask);
            if (e.we) begin
                chk("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
                chk("rf_wd", rf_wd, e.wd);
            end
        end
    end

    task automatic cycle(input logic rst, input logic rwe, input logic [4:0] wreg,
                         input logic [31:0] res, input logic sys, input logic mv,
                         input logic [4:0] mreg, input logic [31:0] mdata);
        exp_t e;
        ent_t h;
        ent_t n;
        bit   preq;
        bit   pop;
        int   old_size;
        @(posedge clk);
        #1;
        rst_n = ~rst; RegWriteW = rwe; WriteRegW = wreg; ResultW = res;
        SyscallW = sys; mdu_valid = mv; mdu_reg = mreg; mdu_data = mdata;
        if (rst) begin
            mq.delete(); m_age = 0; m_drain = 0;
            e = '{we: 1'b0, wa: 5'd0, wd: 32'd0, stall: 1'b0, ready: 1'b1, mask: 32'd0};
            sb.push_back(e);
            return;
        end
        preq = rwe && (wreg != 5'd0);
        old_size = mq.size();
        e.ready = (old_size < DEPTH);
        e.mask = '0;
        foreach (mq[k]) e.mask[mq[k].r] = 1'b1;
        e.stall = (m_drain != 0);
        pop = 0;
        if (old_size == 0 || (m_drain == 0 && preq)) begin
            e.we = preq; e.wa = wreg; e.wd = res;
        end else begin
            h = mq[0]; pop = 1;
            e.we = (h.r != 5'd0); e.wa = h.r; e.wd = h.d;
        end
        sb.push_back(e);
        if (pop) void'(mq.pop_front());
        if (mv && e.ready) begin
            n.r = mreg; n.d = mdata;
            mq.push_back(n);
        end
        if (pop || old_size == 0) m_age = 0;
        else if (m_drain == 0 && m_age < AGE_MAX) m_age++;
        if (m_drain == 1) m_drain = 0;
        else if (m_drain == 2) begin
            if (mq.size() == 0) m_drain = 0;
        end else if (old_size != 0 && mq.size() != 0) begin
            if (sys) m_drain = 2;
            else if (m_age == AGE_MAX) m_drain = 1;
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        cycle(1, 1, 5'd7, 32'hDEAD, 0, 0, 5'd0, 32'd0);
        cycle(1, 1, 5'd7, 32'hDEAD, 1, 1, 5'd1, 32'd1);
        quiet(1);
        // idle pipeline write
        cycle(0, 1, 5'd8, 32'h1234, 0, 0, 5'd0, 32'd0);
        cycle(0, 1, 5'd0, 32'h9999, 0, 0, 5'd0, 32'd0);
        // MDU result while pipeline is quiet
        cycle(0, 0, 5'd0, 32'd0, 0, 1, 5'd9, 32'hAAAA);
        quiet(2);
        // starvation of one entry
        cycle(0, 1, 5'd3, 32'h33, 0, 1, 5'd5, 32'h55);
        for (int i = 0; i < 7; i++) cycle(0, 1, 5'd3, 32'h33 + i, 0, 0, 5'd0, 32'd0);
        quiet(2);
        // full FIFO with pipeline busy
        cycle(0, 1, 5'd4, 32'h40, 0, 1, 5'd10, 32'hA0);
        cycle(0, 1, 5'd4, 32'h41, 0, 1, 5'd11, 32'hA1);
        for (int i = 0; i < 9; i++) cycle(0, 1, 5'd4, 32'h42, 0, 1, 5'd12, 32'hA2 + i);
        quiet(4);
        // syscall drain
        cycle(0, 1, 5'd6, 32'h60, 0, 1, 5'd13, 32'hB0);
        cycle(0, 1, 5'd6, 32'h61, 0, 1, 5'd0, 32'hB1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 5'd6, 32'h62, 1, 0, 5'd0, 32'd0);
        quiet(3);
        // reset during a drain
        cycle(0, 1, 5'd2, 32'h20, 0, 1, 5'd14, 32'hC0);
        cycle(0, 1, 5'd2, 32'h21, 0, 1, 5'd15, 32'hC1);
        cycle(0, 1, 5'd2, 32'h22, 1, 0, 5'd0, 32'd0);
        cycle(0, 1, 5'd2, 32'h22, 1, 0, 5'd0, 32'd0);
        cycle(1, 1, 5'd2, 32'h22, 1, 1, 5'd16, 32'hC2);
        cycle(1, 1, 5'd2, 32'h22, 0, 0, 5'd0, 32'd0);
        quiet(4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rwe;
            logic sys;
            logic mv;
            logic rst;
            rwe = ($urandom_range(0, 99) < 60);
            sys = ($urandom_range(0, 99) < 8);
            mv  = ($urandom_range(0, 99) < 45);
            rst = ($urandom_range(0, 999) < 5);
            cycle(rst, rwe, 5'($urandom_range(0, 31)), $urandom, sys, mv,
                  5'($urandom_range(0, 31)), $urandom);
        end
        quiet(3);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: number of entries in the multi-cycle-unit result FIFO.
REQ-002 Parameter AGE_MAX, default 4: number of cycles a FIFO head may wait before the arbiter forces a pipeline stall.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 RegWriteW  in  1  pipeline writeback write-enable.
REQ-006 WriteRegW  in  5  pipeline writeback destination register.
REQ-007 ResultW  in  32  pipeline writeback data, already muxed between ReadDataW and ALUOutW.
REQ-008 SyscallW  in  1  syscall present in the writeback stage.
REQ-009 mdu_valid  in  1  multiply/divide unit result offered.
REQ-010 mdu_reg  in  5  destination register of the offered result.
REQ-011 mdu_data  in  32  offered result data.
REQ-012 mdu_ready  out  1  FIFO accepts the offered result this cycle.
REQ-013 StallW  out  1  freeze writeback and all earlier stages this cycle.
REQ-014 rf_we, rf_wa, rf_wd  out  1/5/32  register-file write port.
REQ-015 pending_mask  out  32  bit r set while any FIFO entry targets register r.

Function
REQ-016 The pipeline requests the port when RegWriteW=1 and WriteRegW!=0; RegWriteW=1 with WriteRegW=0 counts as no request.
REQ-017 The block SHALL accept an MDU result when mdu_valid & mdu_ready at a clock edge; mdu_ready = (count < DEPTH), with no dependence on a same-cycle dequeue.
REQ-018 There is no bypass: an accepted result becomes eligible for grant no earlier than the cycle after acceptance.
REQ-019 FSM states: IDLE (count=0), PEND (count>0, pipeline has priority), DRAIN (StallW=1, FIFO head has priority).
REQ-020 IDLE: rf_* driven combinationally from the pipeline inputs; rf_we = pipeline request; StallW=0.
REQ-021 PEND: a pipeline request wins; the head is granted (rf_we=1, dequeue at the edge) only in cycles without a pipeline request.
REQ-022 Age counter: cleared on every dequeue and whenever count=0; incremented in each PEND cycle where the head is not granted, saturating at AGE_MAX.
REQ-023 PEND->DRAIN when age reaches AGE_MAX, or when SyscallW=1 with count>0; PEND->IDLE when the last entry dequeues.
REQ-024 DRAIN: StallW=1, the head is granted every cycle and the pipeline write is suppressed; the WB instruction repeats the next cycle because the pipeline is frozen.
REQ-025 DRAIN exit: on age-triggered entry, leave after one dequeue (to PEND if count>0, else IDLE); on syscall-triggered entry, stay until count=0, then IDLE.
REQ-026 A head entry with register 0 is dequeued normally with rf_we=0.
REQ-027 pending_mask is computed from the valid FIFO entries only and updates the cycle after each enqueue or dequeue.
REQ-028 WAW ordering between a pipeline write and a pending entry for the same register is the hazard unit's job, using pending_mask; the arbiter does no reordering.
REQ-029 Simultaneous enqueue and dequeue in one cycle SHALL leave count unchanged, and the FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 Only one write SHALL reach the port per cycle, and the FIFO SHALL preserve MDU results in acceptance order.

Reset
REQ-031 While rst_n=0: state=IDLE, count=0, age=0, pointers=0, pending_mask=0, StallW=0, mdu_ready=1, rf_we=0.
REQ-032 rf_we=0 and StallW=0 SHALL hold combinationally while rst_n=0, regardless of the pipeline inputs.
REQ-033 Reset asserted mid-DRAIN discards all FIFO contents; no entry is written after rst_n deasserts.

Verification
REQ-034 Idle pipeline write: RegWriteW=1, WriteRegW=8, ResultW=0x1234 -> rf_we=1, rf_wa=8, rf_wd=0x1234 in the same cycle, StallW=0.
REQ-035 MDU while the pipeline is quiet: accept {reg 9, 0xAAAA} -> pending_mask=0x200 the next cycle; the write to reg 9 occurs that cycle; pending_mask=0 the cycle after.
REQ-036 Starvation: enqueue {reg 5, 0x55} with a continuous pipeline write to reg 3 -> after 4 blocked cycles StallW=1 for exactly one cycle with rf_wa=5, then the reg-3 write resumes.
REQ-037 Full: accept two results with the pipeline busy -> mdu_ready=0 while count=2, then mdu_ready=1 the cycle after the first dequeue.
REQ-038 Syscall drain: two entries pending plus SyscallW=1 -> StallW=1 for 2 cycles writing both entries in order, then state=IDLE and StallW=0.
REQ-039 Reset mid-drain: rst_n=0 during DRAIN -> outputs match REQ-031 immediately, and no stale write follows deassertion.
